// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares one main memory between I-cache and D-cache block fills
module cache_fill_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int WORDS_PER_BLOCK = 8,
  localparam int LW = $clog2(WORDS_PER_BLOCK),
  localparam int BW = ADDR_W - LW - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss_i,
  input  logic [ADDR_W-1:0] icache_miss_addr_i,
  input  logic              dcache_miss_i,
  input  logic [ADDR_W-1:0] dcache_miss_addr_i,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_data_valid_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] fill_data_o,
  output logic [LW-1:0]     fill_word_o,
  output logic              icache_fill_we_o,
  output logic              dcache_fill_we_o,
  output logic              icache_fill_done_o,
  output logic              dcache_fill_done_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t            state_q;
  logic              owner_q;
  logic              last_q;
  logic [BW-1:0]     blk_q;
  logic [LW-1:0]     issue_q;
  logic [LW-1:0]     recv_q;
  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] fill_data_q;
  logic [LW-1:0]     fill_word_q;
  logic              gnt_d;
  logic [BW-1:0]     blk_d;
  logic [LW-1:0]     issue_d;
  logic              take;
  logic              last_in;
  logic              unused_bits;
  assign unused_bits = ^{icache_miss_addr_i[LW:0], dcache_miss_addr_i[LW:0]};
  // Grant decode (1 = D-cache; a tie goes to whoever was not served last) and return acceptance
  always_comb begin
    gnt_d   = dcache_miss_i & (~icache_miss_i | ~last_q);
    blk_d   = gnt_d ? dcache_miss_addr_i[ADDR_W-1:LW+1] : icache_miss_addr_i[ADDR_W-1:LW+1];
    issue_d = issue_q + 1'b1;
    take    = mem_data_valid_i & (state_q == ISSUE || state_q == DRAIN);
    last_in = take && recv_q == LW'(WORDS_PER_BLOCK - 1);
  end
  // Fill sequencer: grant, issue one word per cycle, collect returns, pulse done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b0;
      blk_q       <= '0;
      issue_q     <= '0;
      recv_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      fill_data_q <= '0;
      fill_word_q <= '0;
    end else begin
      if (take) begin
        fill_data_q <= mem_data_i;
        fill_word_q <= recv_q;
        recv_q      <= recv_q + 1'b1;
      end
      case (state_q)
        IDLE: if (icache_miss_i | dcache_miss_i) begin
          owner_q    <= gnt_d;
          blk_q      <= blk_d;
          issue_q    <= '0;
          recv_q     <= '0;
          mem_en_q   <= 1'b1;
          mem_addr_q <= {blk_d, {LW{1'b0}}, 1'b0};
          state_q    <= ISSUE;
        end
        ISSUE: if (issue_q == LW'(WORDS_PER_BLOCK - 1)) begin
          mem_en_q <= 1'b0;
          state_q  <= last_in ? DONE : DRAIN;
        end else begin
          issue_q    <= issue_d;
          mem_addr_q <= {blk_q, issue_d, 1'b0};
        end
        DRAIN: state_q <= last_in ? DONE : DRAIN;
        default: begin
          last_q  <= owner_q;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign mem_en_o           = mem_en_q;
  assign mem_addr_o         = mem_addr_q;
  assign fill_data_o        = take ? mem_data_i : fill_data_q;
  assign fill_word_o        = take ? recv_q : fill_word_q;
  assign icache_fill_we_o   = take & ~owner_q;
  assign dcache_fill_we_o   = take & owner_q;
  assign icache_fill_done_o = state_q == DONE && !owner_q;
  assign dcache_fill_done_o = state_q == DONE && owner_q;
  assign busy_o             = state_q != IDLE;
endmodule
